uart_row_sender: RTL and testbench

Host-side initiator for the UART row-upload protocol served by `uart2vga_with_answer`. On a start pulse it sends one row packet through an external `uart_transmiter`:

- 2 row-number bytes,
- `BYTE_SIZE_ROW` pixel bytes read from a synchronous buffer,
- the end word.

It consumes the per-byte answers from an external `uart_receiver`, checks each answer code and reports the packet result. It sits in a bridge or pattern-generator FPGA that drives the VGA board over UART.

---
 rtl/uart2vga_pkg.sv | 31 +++
 rtl/uart_answer_timer.sv | 36 +++
 rtl/uart_row_sender.sv | 185 ++++++++++++++++++
 tb/tb_uart_row_sender.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart2vga_pkg.sv
// Shared constants and enums for the UART row-upload protocol.
// Used by the host-side row sender and its answer timer.
package uart2vga_pkg;

  localparam int UART_BYTE_SIZE_ROW = 240;
  localparam int UART_BYTE_SIZE_Y   = 2;
  localparam int UART_TIMEOUT_CYCLES = 50_000;

  localparam logic [7:0] UART_END_WORD     = 8'hDD;
  localparam logic [7:0] UART_ANS_TAKE_ROW = 8'hCC;
  localparam logic [7:0] UART_ANS_CODE     = 8'hAA;
  localparam logic [7:0] UART_ANS_OK       = 8'hFF;
  localparam logic [7:0] UART_ANS_NOT_ALL  = 8'h11;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NAK      = 2'd1,
    ST_ERR_CODE = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_ANS,
    S_WAIT_MISS,
    S_FINISH
  } state_e;

endpackage

// File: rtl/uart_answer_timer.sv
// Answer timeout counter: clr zeroes, en counts, expired at TIMEOUT_CYCLES-1.
// Ports: clk, rst_n, clr, en in; expired out (qualified by en).
module uart_answer_timer
  import uart2vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int LOG_W =
    $clog2(TIMEOUT_CYCLES);
  localparam int CW =
    (LOG_W > 17) ? LOG_W : 17;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_row_sender.sv
// Sends one row packet over UART and checks the per-byte answers.
// Ports: start/row in; rd_addr/rd_data buffer; tx_*/rx_* link; busy/done/status/missing/err_index out.
module uart_row_sender
  import uart2vga_pkg::*;
#(
  parameter int BYTE_SIZE_ROW = UART_BYTE_SIZE_ROW,
  parameter int BYTE_SIZE_Y   = UART_BYTE_SIZE_Y,
  parameter logic [7:0] END_WORD = UART_END_WORD,
  parameter logic [7:0] ANSWER_CODE_TAKE_ROW = UART_ANS_TAKE_ROW,
  parameter logic [7:0] ANSWER_CODE = UART_ANS_CODE,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = UART_ANS_OK,
  parameter logic [7:0] NOT_ALL_RECEIVED = UART_ANS_NOT_ALL,
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] row,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [7:0]  missing,
  output logic [7:0]  err_index
);

  localparam int N = BYTE_SIZE_Y + BYTE_SIZE_ROW + 1;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);
  localparam logic [7:0] Y_IDX = 8'(BYTE_SIZE_Y);

  state_e        state;
  status_e       status_q;
  logic [15:0]   row_q;
  logic [7:0]    idx;
  logic [7:0]    idx_inc;
  logic [7:0]    next_addr;
  logic [7:0]    byte_sel;
  logic          ans_ok;
  logic          tmr_clr;
  logic          tmr_en;
  logic          expired;

  assign status = status_q;

  assign idx_inc = idx + 8'd1;

  // Pixel bytes start after the row-number bytes.
  assign next_addr = (idx_inc >= Y_IDX) ?
                     idx_inc - Y_IDX : 8'd0;

  always_comb begin
    byte_sel = rd_data;
    unique case (1'b1)
      (idx < Y_IDX):
        byte_sel = idx[0] ? row_q[15:8]
                          : row_q[7:0];
      (idx == LAST_IDX):
        byte_sel = END_WORD;
      default:
        byte_sel = rd_data;
    endcase
  end

  assign ans_ok = (idx < Y_IDX) ?
                  (rx_data == ANSWER_CODE_TAKE_ROW) :
                  (rx_data == ANSWER_CODE);

  assign tmr_clr = (state == S_SEND) && !tx_busy;
  assign tmr_en  = (state == S_WAIT_ANS) ||
                   (state == S_WAIT_MISS);

  uart_answer_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      status_q  <= ST_OK;
      row_q     <= '0;
      idx       <= '0;
      rd_addr   <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      missing   <= '0;
      err_index <= '0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            row_q     <= row;
            idx       <= '0;
            rd_addr   <= '0;
            status_q  <= ST_OK;
            missing   <= '0;
            err_index <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_data  <= byte_sel;
            tx_start <= 1'b1;
            state    <= S_WAIT_ANS;
          end
        end
        S_WAIT_ANS: begin
          // An answer in the expiry cycle takes priority.
          if (rx_done) begin
            if (idx == LAST_IDX) begin
              if (rx_data == SUCCESSFULLY_RECEIVED) begin
                status_q <= ST_OK;
                done     <= 1'b1;
                state    <= S_FINISH;
              end else if (rx_data == NOT_ALL_RECEIVED) begin
                state <= S_WAIT_MISS;
              end else begin
                status_q  <= ST_ERR_CODE;
                err_index <= idx;
                done      <= 1'b1;
                state     <= S_FINISH;
              end
            end else if (ans_ok) begin
              idx     <= idx_inc;
              rd_addr <= next_addr;
              state   <= S_FETCH;
            end else begin
              status_q  <= ST_ERR_CODE;
              err_index <= idx;
              done      <= 1'b1;
              state     <= S_FINISH;
            end
          end else if (expired) begin
            status_q  <= ST_TIMEOUT;
            err_index <= idx;
            done      <= 1'b1;
            state     <= S_FINISH;
          end
        end
        S_WAIT_MISS: begin
          if (rx_done) begin
            missing  <= rx_data;
            status_q <= ST_NAK;
            done     <= 1'b1;
            state    <= S_FINISH;
          end else if (expired) begin
            status_q  <= ST_TIMEOUT;
            err_index <= idx;
            done      <= 1'b1;
            state     <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_row_sender.sv
// Bench for uart_row_sender: randomized packets against a behavioural responder.
// Scenario tasks check each feature inline and print one summary line.
module tb_uart_row_sender;

  localparam int N  = 243;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] row = '0;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  missing;
  logic [7:0]  err_index;

  uart_row_sender #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row       (row),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .missing   (missing),
    .err_index (err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int tests = 0;
  int fails = 0;

  // responder configuration, written by the test tasks only
  int         delay = 200;
  int         pkt_base = 0;
  int         fault_idx = -1;
  logic [7:0] fault_code = '0;
  int         silent_idx = -1;
  bit         nak_en = 1'b0;
  logic [7:0] nak_miss = '0;
  int         stray_at = -1;
  logic [7:0] stray_byte = '0;
  int         rx_base = 0;
  int         done_base = 0;
  int         start_cyc = 0;

  // monitor results, written by the responder only
  int         tx_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         tx_cyc_q [$];
  int         rx_cyc_q [$];
  logic [7:0] sent_q [$];
  int         aq_time [$];
  logic [7:0] aq_byte [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      aq_time.delete();
      aq_byte.delete();
      rx_done = 1'b0;
      rx_data = '0;
    end else begin
      if (tx_start) begin
        int i;
        i = tx_cnt - pkt_base;
        sent_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
        tx_cnt++;
        if (i != silent_idx) begin
          if (i == fault_idx) begin
            aq_time.push_back(cyc + delay);
            aq_byte.push_back(fault_code);
          end else if (i == N - 1) begin
            if (nak_en) begin
              aq_time.push_back(cyc + delay);
              aq_byte.push_back(8'h11);
              aq_time.push_back(cyc + 2 * delay);
              aq_byte.push_back(nak_miss);
            end else begin
              aq_time.push_back(cyc + delay);
              aq_byte.push_back(8'hFF);
            end
          end else begin
            aq_time.push_back(cyc + delay);
            aq_byte.push_back(i < 2 ? 8'hCC : 8'hAA);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (aq_time.size() > 0 && aq_time[0] <= cyc) begin
        rx_done = 1'b1;
        rx_data = aq_byte.pop_front();
        void'(aq_time.pop_front());
        rx_cyc_q.push_back(cyc);
      end else if (cyc == stray_at) begin
        rx_done = 1'b1;
        rx_data = stray_byte;
      end else begin
        rx_done = 1'b0;
      end
    end
  end

  function automatic logic [7:0] exp_byte(int i, logic [15:0] r);
    if (i == 0) return r[7:0];
    if (i == 1) return r[15:8];
    if (i == N - 1) return 8'hDD;
    return mem[i - 2];
  endfunction

  function automatic int byte_errs(int n, logic [15:0] r);
    int e = 0;
    for (int k = 0; k < n; k++) begin
      if (pkt_base + k >= sent_q.size()) e++;
      else if (sent_q[pkt_base + k] !== exp_byte(k, r)) e++;
    end
    return e;
  endfunction

  task automatic cfg(int d, int f, logic [7:0] fc,
                     int s, bit nk, logic [7:0] nm);
    delay      = d;
    fault_idx  = f;
    fault_code = fc;
    silent_idx = s;
    nak_en     = nk;
    nak_miss   = nm;
  endtask

  task automatic fill_mem(bit ramp);
    for (int i = 0; i < 256; i++)
      mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic send_pkt(logic [15:0] r);
    pkt_base  = tx_cnt;
    rx_base   = rx_cyc_q.size();
    done_base = done_cnt;
    @(negedge clk);
    row       = r;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    row   = 16'($urandom);
  endtask

  task automatic wait_done(int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt > done_base) begin
        ok = 1'b1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_done: no done within %0d cycles", budget);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({rd_addr, tx_data, tx_start, busy, done,
         status, missing, err_index} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h %h %b %b %b %0d %h %h want all 0",
               rd_addr, tx_data, tx_start, busy, done,
               status, missing, err_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    bit ok;
    int gap_err;
    fill_mem(1'b1);
    cfg(200, -1, 8'h00, -1, 1'b0, 8'h00);
    send_pkt(16'h0122);
    wait_done(60000, ok);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (tx_cnt - pkt_base !== N) begin
      fails++;
      $display("FAIL clean_tx_count: got %0d want %0d", tx_cnt - pkt_base, N);
    end
    tests++;
    if (byte_errs(N, 16'h0122) !== 0) begin
      fails++;
      $display("FAIL clean_bytes: %0d wrong bytes want 0",
               byte_errs(N, 16'h0122));
    end
    tests++;
    if (done_cnt - done_base !== 1) begin
      fails++;
      $display("FAIL clean_done_count: got %0d want 1", done_cnt - done_base);
    end
    tests++;
    if (status !== 2'd0) begin
      fails++;
      $display("FAIL clean_status: got %0d want 0", status);
    end
    tests++;
    if (tx_cyc_q.size() <= pkt_base ||
        tx_cyc_q[pkt_base] - start_cyc !== 3) begin
      fails++;
      $display("FAIL start_latency: want 3 cycles from start to tx_start");
    end
    gap_err = 0;
    for (int k = 1; k < N; k++) begin
      if (pkt_base + k >= tx_cyc_q.size() ||
          rx_base + k - 1 >= rx_cyc_q.size())
        gap_err++;
      else if (tx_cyc_q[pkt_base + k] -
               rx_cyc_q[rx_base + k - 1] != 3)
        gap_err++;
    end
    tests++;
    if (gap_err !== 0) begin
      fails++;
      $display("FAIL rx_to_tx_gap: %0d gaps not 3 cycles want 0", gap_err);
    end
    tests++;
    if (rx_cyc_q.size() == 0 ||
        done_cyc !== rx_cyc_q[rx_cyc_q.size() - 1] + 1) begin
      fails++;
      $display("FAIL clean_done_timing: done at %0d want last rx + 1", done_cyc);
    end
  endtask

  task automatic test_nak();
    bit ok;
    logic [15:0] r;
    r = 16'($urandom);
    fill_mem(1'b0);
    cfg(4, -1, 8'h00, -1, 1'b1, 8'h05);
    send_pkt(r);
    wait_done(5000, ok);
    tests++;
    if (status !== 2'd1) begin
      fails++;
      $display("FAIL nak_status: got %0d want 1", status);
    end
    tests++;
    if (missing !== 8'h05) begin
      fails++;
      $display("FAIL nak_missing: got %h want 05", missing);
    end
    tests++;
    if (rx_cyc_q.size() == 0 ||
        done_cyc !== rx_cyc_q[rx_cyc_q.size() - 1] + 1) begin
      fails++;
      $display("FAIL nak_done_timing: done at %0d want missing rx + 1", done_cyc);
    end
    tests++;
    if (tx_cnt - pkt_base !== N || byte_errs(N, r) !== 0) begin
      fails++;
      $display("FAIL nak_bytes: count %0d errs %0d want %0d and 0",
               tx_cnt - pkt_base, byte_errs(N, r), N);
    end
    tests++;
    if (err_index !== 8'd0) begin
      fails++;
      $display("FAIL nak_err_index: got %0d want 0", err_index);
    end
  endtask

  task automatic test_wrong_code();
    bit ok;
    cfg(4, 1, 8'hAA, -1, 1'b0, 8'h00);
    send_pkt(16'($urandom));
    wait_done(2000, ok);
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (tx_cnt - pkt_base !== 2) begin
      fails++;
      $display("FAIL wrong_tx_count: got %0d want 2", tx_cnt - pkt_base);
    end
    tests++;
    if (status !== 2'd2 || err_index !== 8'd1) begin
      fails++;
      $display("FAIL wrong_status: got %0d idx %0d want 2 idx 1",
               status, err_index);
    end
  endtask

  task automatic test_random_faults();
    bit ok;
    int f;
    logic [7:0] e;
    logic [7:0] c;
    logic [15:0] r;
    for (int it = 0; it < 3; it++) begin
      fill_mem(1'b0);
      r = 16'($urandom);
      f = $urandom_range(0, N - 1);
      e = (f < 2) ? 8'hCC : (f < N - 1) ? 8'hAA : 8'hFF;
      c = 8'($urandom);
      while (c == e || (f == N - 1 && c == 8'h11))
        c = 8'($urandom);
      cfg(4, f, c, -1, 1'b0, 8'h00);
      send_pkt(r);
      wait_done(5000, ok);
      tests++;
      if (status !== 2'd2) begin
        fails++;
        $display("FAIL rnd_status: got %0d want 2 (f=%0d c=%h)", status, f, c);
      end
      tests++;
      if (err_index !== 8'(f)) begin
        fails++;
        $display("FAIL rnd_err_index: got %0d want %0d", err_index, f);
      end
      tests++;
      if (tx_cnt - pkt_base !== f + 1) begin
        fails++;
        $display("FAIL rnd_tx_count: got %0d want %0d", tx_cnt - pkt_base, f + 1);
      end
      tests++;
      if (byte_errs(f + 1, r) !== 0) begin
        fails++;
        $display("FAIL rnd_bytes: %0d wrong bytes want 0", byte_errs(f + 1, r));
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d;
    cfg(200, -1, 8'h00, 10, 1'b0, 8'h00);
    send_pkt(16'($urandom));
    wait_done(10 * 210 + TO + 100, ok);
    tests++;
    if (status !== 2'd3 || err_index !== 8'd10) begin
      fails++;
      $display("FAIL timeout_status: got %0d idx %0d want 3 idx 10",
               status, err_index);
    end
    tests++;
    if (tx_cnt - pkt_base !== 11) begin
      fails++;
      $display("FAIL timeout_tx_count: got %0d want 11", tx_cnt - pkt_base);
    end
    d = (tx_cyc_q.size() > pkt_base + 10) ?
        done_cyc - tx_cyc_q[pkt_base + 10] : -1;
    tests++;
    if (d < TO - 1 || d > TO + 1) begin
      fails++;
      $display("FAIL timeout_delay: got %0d want %0d +-1", d, TO);
    end
    silent_idx = -1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    logic [15:0] r;
    fill_mem(1'b0);
    cfg(4, -1, 8'h00, -1, 1'b0, 8'h00);
    send_pkt(16'($urandom));
    hit = 1'b0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (tx_cnt - pkt_base >= 101) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid_reach: got %0d bytes want 101", tx_cnt - pkt_base);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rd_addr, tx_data, tx_start, busy, done,
         status, missing, err_index} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: busy %b tx %h addr %h want all 0",
               busy, tx_data, rd_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = 16'($urandom);
    fill_mem(1'b0);
    send_pkt(r);
    wait_done(5000, ok);
    tests++;
    if (status !== 2'd0 || tx_cnt - pkt_base !== N ||
        byte_errs(N, r) !== 0) begin
      fails++;
      $display("FAIL reset_mid_after: status %0d count %0d errs %0d want 0 %0d 0",
               status, tx_cnt - pkt_base, byte_errs(N, r), N);
    end
  endtask

  task automatic test_busy_and_stray();
    bit ok;
    int tx_snap;
    int done_snap;
    logic [15:0] r;
    fill_mem(1'b0);
    r = 16'($urandom);
    cfg(4, -1, 8'h00, -1, 1'b0, 8'h00);
    send_pkt(r);
    repeat (20) @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_mid: got %b want 1", busy);
    end
    @(negedge clk);
    start = 1'b1;
    row   = ~r;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, ok);
    repeat (30) @(negedge clk);
    #1;
    tests++;
    if (tx_cnt - pkt_base !== N || done_cnt - done_base !== 1) begin
      fails++;
      $display("FAIL busy_start: tx %0d done %0d want %0d 1",
               tx_cnt - pkt_base, done_cnt - done_base, N);
    end
    tests++;
    if (status !== 2'd0 || busy !== 1'b0 || byte_errs(N, r) !== 0) begin
      fails++;
      $display("FAIL busy_result: status %0d busy %b want 0 0", status, busy);
    end
    tx_snap    = tx_cnt;
    done_snap  = done_cnt;
    stray_byte = 8'($urandom);
    stray_at   = cyc + 2;
    repeat (12) @(negedge clk);
    #1;
    tests++;
    if (status !== 2'd0 || busy !== 1'b0 ||
        tx_cnt !== tx_snap || done_cnt !== done_snap) begin
      fails++;
      $display("FAIL stray_rx: status %0d busy %b tx +%0d done +%0d want 0 0 0 0",
               status, busy, tx_cnt - tx_snap, done_cnt - done_snap);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_nak();
    test_wrong_code();
    test_random_faults();
    test_timeout();
    test_reset_mid();
    test_busy_and_stray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
